fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_queue.sv | 92 +++++++++
 rtl/fetch_unit.sv | 143 ++++++++++++++
 tb/tb_fetch_unit.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared constants and helpers for the decoupled instruction-fetch stage.
//   XLEN    : default PC / instruction width
//   PC_STEP : byte distance between sequential fetches
//   NOP     : canonical RISC-V no-op (addi x0, x0, 0)
//   clog2() : pointer / counter width helper usable in constant expressions
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int          XLEN    = 32;
    localparam int          PC_STEP = 4;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    // Smallest w such that 2**w >= value.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << result) < value) begin
                result = result + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// In-order reservation FIFO for the fetch stage. An entry is allocated (with
// its PC) when a request is issued, filled (with the instruction) when the
// matching response returns, and popped once filled. Responses return in
// request order, so a single fill pointer always addresses the oldest
// unfilled entry.
//
// Ports
//   clk, rst       : clock, synchronous active-high reset
//   i_flush        : drop every entry (redirect)
//   i_alloc        : allocate tail entry with PC i_alloc_pc
//   i_fill         : write i_fill_data into the oldest unfilled entry
//   i_pop          : release the head entry (must be filled)
//   o_count        : allocated entries (filled + awaiting response)
//   o_head_filled  : head entry holds an instruction
//   o_head_pc      : PC of head entry
//   o_head_data    : instruction of head entry
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter int XLEN  = fetch_pkg::XLEN,
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_alloc,
    input  logic [XLEN-1:0]  i_alloc_pc,
    input  logic             i_fill,
    input  logic [XLEN-1:0]  i_fill_data,
    input  logic             i_pop,
    output logic [CNT_W-1:0] o_count,
    output logic             o_head_filled,
    output logic [XLEN-1:0]  o_head_pc,
    output logic [XLEN-1:0]  o_head_data
);

    import fetch_pkg::clog2;

    // DEPTH is a power of two, so pointers wrap naturally.
    localparam int PTR_W = clog2(DEPTH);

    logic [PTR_W-1:0] r_head_ptr;
    logic [PTR_W-1:0] r_alloc_ptr;
    logic [PTR_W-1:0] r_fill_ptr;
    logic [CNT_W-1:0] r_count;
    logic [DEPTH-1:0] r_filled;
    logic [XLEN-1:0]  r_pc   [DEPTH];
    logic [XLEN-1:0]  r_data [DEPTH];

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_head_ptr  <= '0;
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_count     <= '0;
            r_filled    <= '0;
        end else begin
            if (i_alloc) begin
                r_alloc_ptr <= r_alloc_ptr + PTR_W'(1);
            end
            if (i_fill) begin
                r_filled[r_fill_ptr] <= 1'b1;
                r_fill_ptr           <= r_fill_ptr + PTR_W'(1);
            end
            // A popped entry is always filled, so it never collides with the fill.
            if (i_pop) begin
                r_filled[r_head_ptr] <= 1'b0;
                r_head_ptr           <= r_head_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(i_alloc) - CNT_W'(i_pop);
        end
    end

    // NOTE: payload storage is not reset; r_filled and the pointers decide validity.
    always_ff @(posedge clk) begin
        if (i_alloc) begin
            r_pc[r_alloc_ptr] <= i_alloc_pc;
        end
        if (i_fill) begin
            r_data[r_fill_ptr] <= i_fill_data;
        end
    end

    assign o_count       = r_count;
    assign o_head_filled = r_filled[r_head_ptr];
    assign o_head_pc     = r_pc[r_head_ptr];
    assign o_head_data   = r_data[r_head_ptr];

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Decoupled instruction fetch. Generates sequential word-aligned fetch
// addresses, keeps up to MAX_OUTSTANDING requests in flight to instruction
// memory, parks responses in an in-order reservation queue and hands
// {instruction, pc} to decode over valid/ready. A redirect flushes the queue
// and discards responses still in flight for the abandoned path.
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   redirect_valid   : flush and restart fetch at redirect_pc
//   redirect_pc      : new fetch address (bits [1:0] ignored)
//   imem_req_valid   : fetch request
//   imem_req_ready   : memory accepts request
//   imem_addr        : request address
//   imem_rsp_valid   : response beat (in request order)
//   imem_rsp_data    : instruction word
//   out_valid        : head instruction available to decode
//   out_ready        : decode accepts
//   out_instruction  : head instruction (0 when out_valid is low)
//   out_pc           : head PC (0 when out_valid is low)
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int              XLEN            = fetch_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC        = '0,
    parameter int              QUEUE_DEPTH     = 4,
    parameter int              MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instruction,
    output logic [XLEN-1:0] out_pc
);

    import fetch_pkg::PC_STEP;
    import fetch_pkg::clog2;

    localparam int              CNT_W      = clog2(QUEUE_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(QUEUE_DEPTH);
    localparam logic [CNT_W-1:0] MAX_C      = CNT_W'(MAX_OUTSTANDING);
    localparam logic [XLEN-1:0]  STEP_C     = XLEN'(PC_STEP);
    localparam logic [XLEN-1:0]  ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    logic [XLEN-1:0]  r_fetch_pc;
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_drop_cnt;

    logic [CNT_W-1:0] w_count;
    logic             w_head_filled;
    logic [XLEN-1:0]  w_head_pc;
    logic [XLEN-1:0]  w_head_data;
    logic             w_issue;
    logic             w_req_fire;
    logic             w_rsp_fill;
    logic             w_rsp_drop;
    logic             w_out_valid;
    logic             w_pop;
    logic [CNT_W-1:0] w_in_flight;
    logic [CNT_W-1:0] w_redirect_drop;

    // w_count covers filled entries plus entries awaiting data, i.e. the
    // occupancy + outstanding budget the queue must never exceed.
    assign w_issue = !rst && !redirect_valid
                   && (w_count < DEPTH_C)
                   && (r_outstanding < MAX_C)
                   && (r_drop_cnt == '0);
    assign w_req_fire = w_issue && imem_req_ready;

    // Responses belonging to a flushed path come back first (in-order memory),
    // so they are consumed by the drop counter before any real fill.
    assign w_rsp_drop = imem_rsp_valid && (r_drop_cnt != '0);
    assign w_rsp_fill = imem_rsp_valid && !rst && !redirect_valid
                      && (r_drop_cnt == '0) && (r_outstanding != '0);

    assign w_out_valid = !rst && !redirect_valid && w_head_filled;
    assign w_pop       = w_out_valid && out_ready;

    // Every unanswered request is killed by a redirect; one answered in the
    // redirect cycle itself no longer needs to be dropped.
    assign w_in_flight     = r_outstanding + r_drop_cnt;
    assign w_redirect_drop = (imem_rsp_valid && (w_in_flight != '0))
                           ? w_in_flight - CNT_W'(1) : w_in_flight;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc    <= redirect_pc & ALIGN_MASK;
            r_outstanding <= '0;
            r_drop_cnt    <= w_redirect_drop;
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + STEP_C;
            end
            r_outstanding <= r_outstanding + CNT_W'(w_req_fire) - CNT_W'(w_rsp_fill);
            if (w_rsp_drop) begin
                r_drop_cnt <= r_drop_cnt - CNT_W'(1);
            end
        end
    end

    fetch_queue #(
        .XLEN  (XLEN),
        .DEPTH (QUEUE_DEPTH),
        .CNT_W (CNT_W)
    ) u_queue (
        .clk           (clk),
        .rst           (rst),
        .i_flush       (redirect_valid),
        .i_alloc       (w_req_fire),
        .i_alloc_pc    (r_fetch_pc),
        .i_fill        (w_rsp_fill),
        .i_fill_data   (imem_rsp_data),
        .i_pop         (w_pop),
        .o_count       (w_count),
        .o_head_filled (w_head_filled),
        .o_head_pc     (w_head_pc),
        .o_head_data   (w_head_data)
    );

    assign imem_req_valid  = w_issue;
    assign imem_addr       = r_fetch_pc;
    assign out_valid       = w_out_valid;
    assign out_instruction = w_out_valid ? w_head_data : '0;
    assign out_pc          = w_out_valid ? w_head_pc   : '0;

    // A response with nothing in flight is a memory protocol error; the
    // datapath ignores it.
    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (w_in_flight != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit (RESET_PC=0x100, QUEUE_DEPTH=4,
// MAX_OUTSTANDING=2). A behavioural in-order instruction memory answers with
// instr_of(pc); every delivered instruction is checked against the expected
// sequential PC stream.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN            (32),
        .RESET_PC        (RST_PC),
        .QUEUE_DEPTH     (4),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_pc          (out_pc)
    );

    // Stimulus controls
    logic        tb_rst;
    logic        tb_redirect;
    logic [31:0] tb_redirect_pc;
    logic        tb_out_ready;
    logic        ready_toggle;
    logic        rand_ready;
    int          lat_min;
    int          lat_max;
    int          cyc;

    // Memory model: pending requests in issue order
    logic [31:0] mq_addr [$];
    int          mq_due  [$];

    // Samples taken #1 after the falling edge
    logic        s_req_valid;
    logic [31:0] s_addr;
    logic        s_out_valid;
    logic [31:0] s_out_pc;
    logic [31:0] s_out_instr;

    logic [31:0] req_log [$];
    logic [31:0] pop_log [$];
    logic [31:0] exp_pc;

    int n_compared;
    int n_mismatched;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs on the falling edge, sample shortly after,
    // then account for the handshakes that the next rising edge will perform.
    task automatic step();
        @(negedge clk);
        cyc++;
        rst            = tb_rst;
        redirect_valid = tb_redirect;
        redirect_pc    = tb_redirect_pc;
        out_ready      = rand_ready ? 1'($urandom_range(1, 0)) : tb_out_ready;
        imem_req_ready = ready_toggle ? 1'(cyc % 2) : 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (tb_rst) begin
            mq_addr.delete();
            mq_due.delete();
        end else if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(mq_addr[0]);
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        #1;
        s_req_valid = imem_req_valid;
        s_addr      = imem_addr;
        s_out_valid = out_valid;
        s_out_pc    = out_pc;
        s_out_instr = out_instruction;
        if (s_req_valid && imem_req_ready) begin
            mq_addr.push_back(s_addr);
            mq_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
            req_log.push_back(s_addr);
        end
        if (s_out_valid && out_ready) begin
            pop_log.push_back(s_out_pc);
            check("stream_pc", s_out_pc, exp_pc);
            check("stream_instr", s_out_instr, instr_of(exp_pc));
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic do_reset();
        tb_rst = 1'b1;
        repeat (2) step();
        tb_rst = 1'b0;
        exp_pc = RST_PC;
        req_log.delete();
        pop_log.delete();
    endtask

    initial begin
        n_compared     = 0;
        n_mismatched   = 0;
        cyc            = 0;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        out_ready      = 1'b1;
        tb_rst         = 1'b1;
        tb_redirect    = 1'b0;
        tb_redirect_pc = '0;
        tb_out_ready   = 1'b1;
        ready_toggle   = 1'b0;
        rand_ready     = 1'b0;
        lat_min        = 1;
        lat_max        = 1;
        exp_pc         = RST_PC;

        // Reset state and first-fetch latency with a 1-cycle memory
        repeat (3) step();
        check("rst_req_valid", 32'(s_req_valid), 32'd0);
        check("rst_out_valid", 32'(s_out_valid), 32'd0);
        check("rst_out_pc", s_out_pc, 32'd0);
        check("rst_out_instr", s_out_instr, 32'd0);
        tb_rst = 1'b0;
        step();
        check("c0_req_valid", 32'(s_req_valid), 32'd1);
        check("c0_addr", s_addr, 32'h100);
        check("c0_out_valid", 32'(s_out_valid), 32'd0);
        check("c0_out_instr", s_out_instr, 32'd0);
        step();
        check("c1_addr", s_addr, 32'h104);
        check("c1_out_valid", 32'(s_out_valid), 32'd0);
        step();
        check("c2_out_valid", 32'(s_out_valid), 32'd1);
        check("c2_out_pc", s_out_pc, 32'h100);
        repeat (7) step();
        check("steady_pops", 32'(pop_log.size()), 32'd8);
        check("steady_reqs", 32'(req_log.size()), 32'd10);
        check("steady_last_req", req_log[9], 32'h124);

        // Back-pressure: queue fills with exactly four requests
        tb_out_ready = 1'b0;
        do_reset();
        repeat (8) step();
        check("full_reqs", 32'(req_log.size()), 32'd4);
        check("full_last_req", req_log[3], 32'h10C);
        check("full_req_valid", 32'(s_req_valid), 32'd0);
        check("full_out_valid", 32'(s_out_valid), 32'd1);
        check("full_out_pc", s_out_pc, 32'h100);
        tb_out_ready = 1'b1;
        step();
        tb_out_ready = 1'b0;
        step();
        check("refill_req_valid", 32'(s_req_valid), 32'd1);
        check("refill_addr", s_addr, 32'h110);
        repeat (3) step();
        check("refill_reqs", 32'(req_log.size()), 32'd5);
        check("refill_stop", 32'(s_req_valid), 32'd0);
        check("refill_head_pc", s_out_pc, 32'h104);

        // Redirect to 0x203 with two requests outstanding (3-cycle memory)
        tb_out_ready = 1'b1;
        lat_min = 3;
        lat_max = 3;
        do_reset();
        repeat (2) step();
        check("pre_redir_reqs", 32'(req_log.size()), 32'd2);
        exp_pc = 32'h200;
        pop_log.delete();
        tb_redirect    = 1'b1;
        tb_redirect_pc = 32'h203;
        step();
        check("redir_out_valid", 32'(s_out_valid), 32'd0);
        check("redir_req_valid", 32'(s_req_valid), 32'd0);
        tb_redirect = 1'b0;
        repeat (2) step();
        check("drop_no_issue", 32'(req_log.size()), 32'd2);
        check("drop_req_valid", 32'(s_req_valid), 32'd0);
        step();
        check("restart_req_valid", 32'(s_req_valid), 32'd1);
        check("restart_addr", s_addr, 32'h200);
        repeat (10) step();
        check("redir_first_pc", pop_log[0], 32'h200);

        // Redirect while the head is filled; fetch address wraps past 2^32
        lat_min = 1;
        lat_max = 1;
        do_reset();
        repeat (5) step();
        check("wrap_pre_out_valid", 32'(s_out_valid), 32'd1);
        exp_pc = 32'hFFFF_FFFC;
        req_log.delete();
        pop_log.delete();
        tb_redirect    = 1'b1;
        tb_redirect_pc = 32'hFFFF_FFFC;
        step();
        check("wrap_redir_out_valid", 32'(s_out_valid), 32'd0);
        tb_redirect = 1'b0;
        repeat (6) step();
        check("wrap_req0", req_log[0], 32'hFFFF_FFFC);
        check("wrap_req1", req_log[1], 32'h0000_0000);
        check("wrap_pop1", pop_log[1], 32'h0000_0000);

        // Back-to-back redirects with slow memory: drop count must accumulate
        lat_min = 4;
        lat_max = 4;
        repeat (10) step();
        exp_pc = 32'h500;
        pop_log.delete();
        tb_redirect    = 1'b1;
        tb_redirect_pc = 32'h400;
        step();
        tb_redirect_pc = 32'h500;
        step();
        tb_redirect = 1'b0;
        repeat (20) step();
        check("dbl_redir_first_pc", pop_log[0], 32'h500);
        check("dbl_redir_progress", 32'(pop_log.size() >= 3), 32'd1);

        // Toggling request-ready, random latency and random decode stalls
        lat_min      = 1;
        lat_max      = 4;
        ready_toggle = 1'b1;
        rand_ready   = 1'b1;
        exp_pc       = 32'h300;
        pop_log.delete();
        tb_redirect    = 1'b1;
        tb_redirect_pc = 32'h300;
        step();
        tb_redirect = 1'b0;
        repeat (200) step();
        check("rand_progress", 32'(pop_log.size() >= 20), 32'd1);

        // Reset mid-stream with a full queue
        ready_toggle = 1'b0;
        rand_ready   = 1'b0;
        lat_min      = 1;
        lat_max      = 1;
        tb_out_ready = 1'b0;
        repeat (10) step();
        check("mid_full_req_valid", 32'(s_req_valid), 32'd0);
        check("mid_full_out_valid", 32'(s_out_valid), 32'd1);
        tb_rst = 1'b1;
        step();
        check("mid_rst_out_valid", 32'(s_out_valid), 32'd0);
        check("mid_rst_req_valid", 32'(s_req_valid), 32'd0);
        check("mid_rst_out_pc", s_out_pc, 32'd0);
        tb_rst       = 1'b0;
        tb_out_ready = 1'b1;
        exp_pc       = RST_PC;
        req_log.delete();
        pop_log.delete();
        step();
        check("post_rst_out_valid", 32'(s_out_valid), 32'd0);
        check("post_rst_req_valid", 32'(s_req_valid), 32'd1);
        check("post_rst_addr", s_addr, RST_PC);
        repeat (9) step();
        check("post_rst_pops", 32'(pop_log.size()), 32'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
